// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrck/sdata in the clk domain and emits one signed sample per frame.
// Define I2S_RX_MONO_MIX_EN to emit (L+R)>>>1 on right-word completion instead of the left word.
module i2s_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bclk,
    input  logic                         lrck,
    input  logic                         sdata,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         vld_o,
    output logic                         err_o
);
    localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    logic [1:0] bclk_sync, lrck_sync, sdata_sync;
    logic       bclk_last;
    logic       rise_p0, lrck_p0, sdata_p0;

    state_t                       state, state_n;
    logic [CNT_W-1:0]             bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0]        shreg, shreg_n;
    logic signed [DATA_WIDTH-1:0] left_word, left_word_n;
    logic                         lrck_prev, lrck_prev_n;
    logic                         err_n;
    logic                         changed;
    logic                         emit, vld_p1;

`ifdef I2S_RX_MONO_MIX_EN
    logic signed [DATA_WIDTH-1:0] right_word, right_word_n;
    logic                         left_ok, left_ok_n;

    // Average in one extra bit of headroom, then keep the upper DATA_WIDTH bits.
    function automatic logic signed [DATA_WIDTH-1:0] mix_avg(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] sum;
        sum = a + b;
        return sum[DATA_WIDTH:1];
    endfunction
`endif

    // Synchronizers
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync  <= '0;
            lrck_sync  <= '0;
            sdata_sync <= '0;
            bclk_last  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[0], bclk};
            lrck_sync  <= {lrck_sync[0], lrck};
            sdata_sync <= {sdata_sync[0], sdata};
            bclk_last  <= bclk_sync[1];
        end
    end

    // Stage p0: registered bclk rise with the lrck/sdata values it samples
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_p0  <= 1'b0;
            lrck_p0  <= 1'b0;
            sdata_p0 <= 1'b0;
        end else begin
            rise_p0  <= bclk_sync[1] & ~bclk_last;
            lrck_p0  <= lrck_sync[1];
            sdata_p0 <= sdata_sync[1];
        end
    end

    // Stage p1: frame state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            left_word  <= '0;
            lrck_prev  <= 1'b0;
            err_o      <= 1'b0;
            vld_p1     <= 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
            right_word <= '0;
            left_ok    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            left_word  <= left_word_n;
            lrck_prev  <= lrck_prev_n;
            err_o      <= err_n;
            vld_p1     <= emit;
`ifdef I2S_RX_MONO_MIX_EN
            right_word <= right_word_n;
            left_ok    <= left_ok_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        left_word_n  = left_word;
        lrck_prev_n  = lrck_prev;
        err_n        = err_o;
        changed      = 1'b0;
        emit         = 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
        right_word_n = right_word;
        left_ok_n    = left_ok;
`endif
        if (rise_p0) begin
            lrck_prev_n = lrck_p0;
            changed     = (lrck_p0 != lrck_prev);
            case (state)
                IDLE: begin
                    if (changed) begin
                        state_n   = RUN;
                        bit_cnt_n = '0;
                        shreg_n   = '0;
                    end
                end
                RUN: begin
                    if (changed) begin
                        // One-bit delay slot of the new channel; a cut-short word is dropped here.
                        if (bit_cnt != '0 && bit_cnt < CNT_DATA) err_n = 1'b1;
                        bit_cnt_n = '0;
                        shreg_n   = '0;
`ifdef I2S_RX_MONO_MIX_EN
                        if (!lrck_p0) left_ok_n = 1'b0;
`endif
                    end else if (bit_cnt == CNT_SLOT) begin
                        err_n = 1'b1;
`ifdef I2S_RX_MONO_MIX_EN
                        if (!lrck_p0) left_ok_n = 1'b0;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt_n <= CNT_DATA) shreg_n = {shreg[DATA_WIDTH-2:0], sdata_p0};
                        if (bit_cnt_n == CNT_DATA) begin
                            if (!lrck_p0) begin
                                left_word_n = shreg_n;
`ifdef I2S_RX_MONO_MIX_EN
                                left_ok_n   = 1'b1;
`else
                                emit        = 1'b1;
`endif
                            end
`ifdef I2S_RX_MONO_MIX_EN
                            else begin
                                right_word_n = shreg_n;
                                emit         = left_ok;
                                left_ok_n    = 1'b0;
                            end
`endif
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Stage p2: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
            vld_o  <= 1'b0;
        end else begin
            vld_o <= vld_p1;
            if (vld_p1) begin
`ifdef I2S_RX_MONO_MIX_EN
                data_o <= mix_avg(left_word, right_word);
`else
                data_o <= left_word;
`endif
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames at bclk = clk/8 into a 24/32 and a 24/24 instance and checks both.
module tb_i2s_rx;
    localparam int DW = 24;
`ifdef I2S_RX_MONO_MIX_EN
    localparam bit MIX = 1'b1;
`else
    localparam bit MIX = 1'b0;
`endif

    typedef logic [DW-1:0] wq_t[$];
    typedef int iq_t[$];
    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [DW-1:0] exp_left;
        logic [DW-1:0] exp_mix;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk = 1'b0, lrck = 1'b0, sdata = 1'b0;
    logic [DW-1:0] data0, data1;
    logic vld0, vld1, err0, err1;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_rx #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .bclk(bclk), .lrck(lrck), .sdata(sdata),
        .data_o(data0), .vld_o(vld0), .err_o(err0));
    i2s_rx #(.DATA_WIDTH(24), .SLOT_WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .bclk(bclk), .lrck(lrck), .sdata(sdata),
        .data_o(data1), .vld_o(vld1), .err_o(err1));

    // Capture every output pulse with the clk count it appeared at.
    logic [DW-1:0] got_d0[$], got_d1[$];
    int got_c0[$], got_c1[$];
    int dbl0 = 0, dbl1 = 0;
    logic pv0 = 1'b0, pv1 = 1'b0;
    always @(negedge clk) begin
        if (vld0) begin
            got_d0.push_back(data0);
            got_c0.push_back(cyc);
        end
        if (vld1) begin
            got_d1.push_back(data1);
            got_c1.push_back(cyc);
        end
        if (vld0 && pv0) dbl0 <= dbl0 + 1;
        if (vld1 && pv1) dbl1 <= dbl1 + 1;
        pv0 <= vld0;
        pv1 <= vld1;
    end

    int n_chk = 0, n_pass = 0;
    logic [DW-1:0] exp_d0[$], exp_d1[$];
    int exp_m0[$], exp_m1[$];
    logic exp_err0, exp_err1;
    int base0, base1, dbase0, dbase1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit emits(input int nl, input int nr, input int sw);
        if (MIX) return (nl >= DW) && (nl <= sw) && (nr >= DW);
        return nl >= DW;
    endfunction

    function automatic logic [DW-1:0] mix_ref(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int lv, rv;
        lv = l[DW-1] ? int'(l) - (1 << DW) : int'(l);
        rv = r[DW-1] ? int'(r) - (1 << DW) : int'(r);
        return DW'((lv + rv) >>> 1);
    endfunction

    function automatic int rand_len();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return $urandom_range(8, 23);
        if (k == 1) return $urandom_range(33, 36);
        return $urandom_range(24, 32);
    endfunction

    // One bclk period; lrck/sdata change with the falling edge. mark = clk count at the edge that sees the rise.
    task automatic send_bit(input logic lr, input logic b, output int mark);
        bclk = 1'b0;
        lrck = lr;
        sdata = b;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        mark = cyc + 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int n, output int mark_lsb);
        int m;
        mark_lsb = -1;
        send_bit(lr, 1'($urandom), m);
        for (int i = 1; i <= n; i++) begin
            send_bit(lr, (i <= DW) ? w[DW-i] : 1'($urandom), m);
            if (i == DW) mark_lsb = m;
        end
        if ((n >= 1 && n < DW) || n > 32) exp_err0 = 1'b1;
        if ((n >= 1 && n < DW) || n > 24) exp_err1 = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nl, input int nr);
        int ml, mr;
        logic [DW-1:0] v;
        send_slot(1'b0, l, nl, ml);
        send_slot(1'b1, r, nr, mr);
        v = MIX ? mix_ref(l, r) : l;
        if (emits(nl, nr, 32)) begin
            exp_d0.push_back(v);
            exp_m0.push_back(MIX ? mr : ml);
        end
        if (emits(nl, nr, 24)) begin
            exp_d1.push_back(v);
            exp_m1.push_back(MIX ? mr : ml);
        end
    endtask

    task automatic model_clear();
        exp_d0.delete(); exp_d1.delete();
        exp_m0.delete(); exp_m1.delete();
        exp_err0 = 1'b0;
        exp_err1 = 1'b0;
        base0 = got_d0.size();
        base1 = got_d1.size();
        dbase0 = dbl0;
        dbase1 = dbl1;
    endtask

    task automatic seg_start(input string tag);
        int m;
        rst = 1'b1;
        bclk = 1'b0;
        lrck = 1'b0;
        sdata = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_rst_data"}, {data1, data0}, 0);
        chk({tag, "_rst_vld"}, {vld1, vld0}, 0);
        chk({tag, "_rst_err"}, {err1, err0}, 0);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'($urandom), m);
        send_slot(1'b1, DW'($urandom), 24, m);
    endtask

    task automatic cmp_dut(input string tag, input wq_t gd, input iq_t gc, input int base,
                           input wq_t ed, input iq_t em, input int dbl, input logic err, input logic eerr);
        int n;
        n = gd.size() - base;
        chk({tag, "_count"}, n, ed.size());
        for (int i = 0; i < ed.size() && i < n; i++) begin
            chk({tag, "_data"}, gd[base+i], ed[i]);
            chk({tag, "_latency"}, gc[base+i] - em[i], 4);
        end
        chk({tag, "_pulse_width"}, dbl, 0);
        chk({tag, "_err"}, err, eerr);
    endtask

    task automatic seg_end(input string tag);
        int m;
        send_bit(1'b0, 1'b0, m);
        repeat (8) @(negedge clk);
        cmp_dut({tag, "_s32"}, got_d0, got_c0, base0, exp_d0, exp_m0, dbl0 - dbase0, err0, exp_err0);
        cmp_dut({tag, "_s24"}, got_d1, got_c1, base1, exp_d1, exp_m1, dbl1 - dbase1, err1, exp_err1);
    endtask

    vec_t tbl[4];

    initial begin
        int m;
        logic [DW-1:0] want;
        tbl[0] = '{24'h123456, 24'h654321, 24'h123456, 24'h3BBBBB};
        tbl[1] = '{24'h800000, 24'h800000, 24'h800000, 24'h800000};
        tbl[2] = '{24'h7FFFFF, 24'h000001, 24'h7FFFFF, 24'h400000};
        tbl[3] = '{24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000000};

        // Directed vectors, 32-bclk slots
        for (int t = 0; t < 4; t++) begin
            seg_start("tbl");
            send_frame(tbl[t].l, tbl[t].r, 31, 31);
            send_frame(tbl[t].l, tbl[t].r, 31, 31);
            seg_end("tbl");
            want = MIX ? tbl[t].exp_mix : tbl[t].exp_left;
            if (got_d0.size() > base0) chk("tbl_const", got_d0[base0], want);
            else chk("tbl_const_present", 0, 1);
        end

        // Short left slot: dropped, error sticks through good frames
        seg_start("short");
        send_frame(DW'($urandom), DW'($urandom), 31, 31);
        send_frame(DW'($urandom), DW'($urandom), 16, 31);
        repeat (8) @(negedge clk);
        chk("short_err_mid", err0, exp_err0);
        send_frame(DW'($urandom), DW'($urandom), 31, 31);
        send_frame(DW'($urandom), DW'($urandom), 31, 31);
        seg_end("short");

        // Slots exactly DATA_WIDTH long, back to back
        seg_start("w24");
        for (int i = 0; i < 6; i++) send_frame(DW'($urandom), DW'($urandom), 24, 24);
        seg_end("w24");

        // One bit too many for the 24-bit-slot instance
        seg_start("long");
        send_frame(DW'($urandom), DW'($urandom), 25, 24);
        send_frame(DW'($urandom), DW'($urandom), 24, 24);
        seg_end("long");

        // Reset in the middle of a left word, then relock
        seg_start("midrst");
        send_frame(24'h5A5A5A, 24'h0F0F0F, 31, 31);
        send_bit(1'b0, 1'b1, m);
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1, m);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data", {data1, data0}, 0);
        chk("midrst_vld", {vld1, vld0}, 0);
        chk("midrst_err", {err1, err0}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 21; i++) send_bit(1'b0, 1'($urandom), m);
        send_slot(1'b1, DW'($urandom), 31, m);
        send_frame(24'hA1B2C3, 24'h1D2E3F, 31, 31);
        seg_end("midrst");

        // Randomized frames with occasional short/long slots
        seg_start("rand");
        for (int i = 0; i < 16; i++) send_frame(DW'($urandom), DW'($urandom), rand_len(), rand_len());
        seg_end("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
